adder_result_display: RTL and testbench

//  Downstream stage of the 4-bit look-ahead adder on the lab FPGA board.
//  - Captures the adder's 5-bit result {Cout,S} (0..31) on a load strobe.
//  - Converts it to two BCD digits with a sequential double-dabble FSM.
//  - Time-multiplexes the digits onto the board's 4-digit common-anode seven-segment display.

---
 rtl/adder_disp_pkg.sv | 27 ++
 rtl/adder_result_display_bcd_to_seg7.sv | 26 ++
 rtl/adder_result_display.sv | 125 ++++++++++++
 tb/tb_adder_result_display.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_disp_pkg.sv
// Shared types and constants for the adder result display.
package adder_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK   = 7'h7F;
    localparam logic [2:0] SHIFT_COUNT = 3'd5;

    // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9.
    localparam logic [6:0] SEG_CODE [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    localparam logic [3:0] DIGIT_AN [0:3] = '{
        4'b1110, 4'b1101, 4'b1011, 4'b0111
    };

    function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/adder_result_display_bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment decoder; non-BCD codes blank.
module bcd_to_seg7
    import adder_disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0: seg_o = SEG_CODE[0];
            4'd1: seg_o = SEG_CODE[1];
            4'd2: seg_o = SEG_CODE[2];
            4'd3: seg_o = SEG_CODE[3];
            4'd4: seg_o = SEG_CODE[4];
            4'd5: seg_o = SEG_CODE[5];
            4'd6: seg_o = SEG_CODE[6];
            4'd7: seg_o = SEG_CODE[7];
            4'd8: seg_o = SEG_CODE[8];
            4'd9: seg_o = SEG_CODE[9];
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/adder_result_display.sv
// Captures the 5-bit adder result, converts it to BCD by double-dabble and multiplexes
// it onto a 4-digit common-anode display. Option: LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module adder_result_display
    import adder_disp_pkg::*;
#(
    parameter int REFRESH_BITS = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sum_in,
    input  logic       cout_in,
    input  logic       load,
    output logic       busy,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    state_e            state_q, state_d;
    logic [4:0]        val_q, val_d;
    logic [7:0]        bcd_q, bcd_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [3:0]        tens_q, tens_d;
    logic [3:0]        units_q, units_d;
    logic [REFRESH_BITS-1:0] refresh_q;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;

    logic [7:0]        bcd_adj;
    logic [1:0]        sel;
    logic [3:0]        digit;
    logic              digit_blank;
    logic [6:0]        digit_seg;

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        tens_d  = tens_q;
        units_d = units_q;
        bcd_adj = {dabble_adj(bcd_q[7:4]), dabble_adj(bcd_q[3:0])};
        case (state_q)
            IDLE: begin
                if (load) begin
                    val_d   = {cout_in, sum_in};
                    bcd_d   = 8'd0;
                    cnt_d   = SHIFT_COUNT;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, val_d} = {bcd_adj[6:0], val_q, 1'b0};
                cnt_d          = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                tens_d  = bcd_q[7:4];
                units_d = bcd_q[3:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Digits are taken from the next-state values so a finished conversion
    // reaches the segment register on the same edge that commits it.
    assign sel = refresh_q[REFRESH_BITS-1 -: 2];

    always_comb begin
        digit       = units_d;
        digit_blank = 1'b0;
        case (sel)
            2'd0: digit = units_d;
            2'd1: begin
                digit = tens_d;
`ifdef LEADING_ZERO_BLANK_EN
                digit_blank = (tens_d == 4'd0);
`else
                digit_blank = 1'b0;
`endif
            end
            default: digit_blank = 1'b1;
        endcase
        an_d  = DIGIT_AN[sel];
        seg_d = digit_blank ? SEG_BLANK : digit_seg;
    end

    bcd_to_seg7 u_dec (
        .bcd_i (digit),
        .seg_o (digit_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            val_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            tens_q    <= '0;
            units_q   <= '0;
            refresh_q <= '0;
            an_q      <= 4'b1111;
            seg_q     <= SEG_BLANK;
        end else begin
            state_q   <= state_d;
            val_q     <= val_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            tens_q    <= tens_d;
            units_q   <= units_d;
            refresh_q <= refresh_q + 1'b1;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = 1'b1;

endmodule

// File: tb/tb_adder_result_display.sv
// Scoreboard bench for adder_result_display with a 3-bit refresh counter.
module tb_adder_result_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sum_in;
    logic       cout_in;
    logic       load;
    logic       busy;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_vec  = 0;
    int n_miss = 0;
    int exp_q[$];
    bit mon_active = 1'b0;

    always #5 clk = ~clk;

    adder_result_display #(.REFRESH_BITS(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .sum_in  (sum_in),
        .cout_in (cout_in),
        .load    (load),
        .busy    (busy),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    function automatic logic [6:0] seg_code(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] exp_tens(input int v);
`ifdef LEADING_ZERO_BLANK_EN
        if (v / 10 == 0) return 7'h7F;
`endif
        return seg_code(v / 10);
    endfunction

    function automatic logic [3:0] next_an(input logic [3:0] a);
        case (a)
            4'b1110: return 4'b1101;
            4'b1101: return 4'b1011;
            4'b1011: return 4'b0111;
            default: return 4'b1110;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic c, input logic [3:0] s);
        cout_in = c;
        sum_in  = s;
        load    = 1'b1;
        exp_q.push_back({27'd0, c, s});
        tick();
        load = 1'b0;
    endtask

    task automatic read_display(output logic [31:0] t, output logic [31:0] u);
        t = '1;
        u = '1;
        repeat (8) begin
            tick();
            if (an == 4'b1110) u = {25'd0, seg};
            else if (an == 4'b1101) t = {25'd0, seg};
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((exp_q.size() != 0 || mon_active) && k < 60) begin
            tick();
            k++;
        end
        check_val("drain", exp_q.size(), 0);
    endtask

    // Monitor: each completed conversion pops one expected value and checks both digits.
    initial begin
        bit prev = 1'b0;
        int v;
        logic [31:0] t, u;
        forever begin
            @(posedge clk);
            #1;
            if (prev && !busy && !rst) begin
                check_val("sb_depth", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    v = exp_q.pop_front();
                    mon_active = 1'b1;
                    t = '1;
                    u = '1;
                    for (int k = 0; k < 7; k++) begin
                        if (k > 0) begin
                            @(posedge clk);
                            #1;
                        end
                        if (rst) break;
                        if (an == 4'b1110) u = {25'd0, seg};
                        else if (an == 4'b1101) t = {25'd0, seg};
                    end
                    if (!rst) begin
                        check_val("units_seg", u, {25'd0, seg_code(v % 10)});
                        check_val("tens_seg", t, {25'd0, exp_tens(v)});
                        $display("txn value=%0d tens_seg=%h units_seg=%h", v, t[6:0], u[6:0]);
                    end
                    mon_active = 1'b0;
                end
            end
            prev = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t, u;
        int cnt;
        int changes;
        logic [3:0] prev_an;

        // 1) reset state and idle display
        rst = 1'b1; load = 1'b0; sum_in = 4'h0; cout_in = 1'b0;
        #2;
        check_val("rst_an", an, 4'b1111);
        check_val("rst_seg", seg, 7'h7F);
        check_val("rst_busy", busy, 0);
        check_val("rst_dp", dp, 1);
        repeat (3) tick();
        check_val("rst_hold_an", an, 4'b1111);
        rst = 1'b0;
        read_display(t, u);
        check_val("init_units", u, {25'd0, seg_code(0)});
        check_val("init_tens", t, {25'd0, exp_tens(0)});

        // 2) 31 with busy length
        do_load(1'b1, 4'hF);
        cnt = 0;
        while (busy && cnt < 20) begin
            cnt++;
            tick();
        end
        check_val("busy_cycles", cnt, 6);
        wait_idle();

        // 3) load while busy is ignored
        do_load(1'b0, 4'h9);
        tick();
        sum_in = 4'h2;
        load   = 1'b1;
        tick();
        load   = 1'b0;
        check_val("busy_during_ignored", busy, 1);
        wait_idle();

        // 4) reset during SHIFT cycle 3
        cout_in = 1'b1; sum_in = 4'hA; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check_val("midrst_busy", busy, 0);
        check_val("midrst_an", an, 4'b1111);
        check_val("midrst_seg", seg, 7'h7F);
        tick();
        #2 rst = 1'b0;
        read_display(t, u);
        check_val("post_rst_units", u, {25'd0, seg_code(0)});
        check_val("post_rst_tens", t, {25'd0, exp_tens(0)});
        do_load(1'b1, 4'hA);
        wait_idle();

        // 5) refresh walk
        prev_an = an;
        changes = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (an != prev_an) begin
                changes++;
                check_val("an_walk", an, next_an(prev_an));
            end
            if (an == 4'b1011 || an == 4'b0111) check_val("blank_digit", seg, 7'h7F);
            prev_an = an;
        end
        check_val("an_changes", changes, 16);

        // 6) full sweep, loads 7 cycles apart
        for (int v = 0; v < 32; v++) begin
            do_load(v[4], v[3:0]);
            repeat (6) tick();
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
